// File: rtl/sarray_pkg.sv
// Shared constants and state encoding for the systolic array sequencer.
// Holds array geometry, TMMA field widths and the default drain length.
package sarray_pkg;

    localparam int SARRAY_H             = 64;
    localparam int TMMA_CNT_WIDTH       = 8;
    localparam int TMMA_PRECISION_WIDTH = 2;
    localparam int DRAIN_CYC            = 130;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FEED,
        ST_DRAIN,
        ST_STORE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/sarray_lane_gen.sv
// Per-lane wavefront window: lane LANE is active for LANE <= s < LANE+K.
// Ports: en_i gate, s_i feed step, k_i K steps; valid_o, cnt_o = s-LANE.
module sarray_lane_gen
    import sarray_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int S_W   = 14,
    parameter int LANE  = 0
) (
    input  logic             en_i,
    input  logic [S_W-1:0]   s_i,
    input  logic [CNT_W-1:0] k_i,
    output logic             valid_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [S_W-1:0] R = S_W'(LANE);

    logic [S_W-1:0] off;

    // off is only meaningful when s_i >= R, which gates valid_o
    assign off     = s_i - R;
    assign valid_o = en_i && (s_i >= R) && (off < S_W'(k_i));
    assign cnt_o   = valid_o ? off[CNT_W-1:0] : '0;

endmodule

// File: rtl/sarray_ctrl.sv
// TMMA tile sequencer: skewed feed wavefront, drain wait, store-C, row count.
// Ports: cmd_* in, rd_* / left_* / top_* / post_storec / busy / done / err out.
module sarray_ctrl #(
    parameter int SARRAY_H  = sarray_pkg::SARRAY_H,
    parameter int CNT_W     = sarray_pkg::TMMA_CNT_WIDTH,
    parameter int PREC_W    = sarray_pkg::TMMA_PRECISION_WIDTH,
    parameter int DRAIN_CYC = sarray_pkg::DRAIN_CYC
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [CNT_W-1:0]          cmd_k_i,
    input  logic                      cmd_type_i,
    input  logic [PREC_W-1:0]         cmd_prec_i,
    input  logic                      cmd_acc_i,
    output logic                      rd_valid_o,
    output logic [CNT_W-1:0]          rd_idx_o,
    output logic [SARRAY_H-1:0]       left_valid_o,
    output logic [CNT_W*SARRAY_H-1:0] left_cnt_o,
    output logic [SARRAY_H-1:0]       left_type_o,
    output logic [PREC_W*SARRAY_H-1:0] left_prec_o,
    output logic [SARRAY_H:0]         left_acc_o,
    output logic [SARRAY_H-1:0]       top_valid_o,
    output logic [CNT_W*SARRAY_H-1:0] top_cnt_o,
    output logic                      post_storec_valid_o,
    input  logic [SARRAY_H:0]         bot_valid_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o
);

    import sarray_pkg::*;

    // step counter must reach K+H-2
    localparam int S_W = CNT_W + $clog2(SARRAY_H) + 1;
    localparam int D_W = $clog2(DRAIN_CYC + 1);
    localparam int B_W = $clog2(SARRAY_H + 1);

    state_e                      state_q;
    logic [S_W-1:0]              s_q;
    logic [D_W-1:0]              d_q;
    logic [B_W-1:0]              b_q;
    logic [CNT_W-1:0]            k_q;
    logic                        type_q;
    logic [PREC_W-1:0]           prec_q;
    logic                        acc_q;

    logic                        rd_valid_q;
    logic [CNT_W-1:0]            rd_idx_q;
    logic [SARRAY_H-1:0]         left_valid_q;
    logic [CNT_W*SARRAY_H-1:0]   left_cnt_q;
    logic [SARRAY_H-1:0]         left_type_q;
    logic [PREC_W*SARRAY_H-1:0]  left_prec_q;
    logic [SARRAY_H:0]           left_acc_q;
    logic                        post_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        err_q;

    logic [SARRAY_H-1:0]         lane_valid_d;
    logic [CNT_W*SARRAY_H-1:0]   lane_cnt_d;
    logic [SARRAY_H-1:0]         lane_type_d;
    logic [PREC_W*SARRAY_H-1:0]  lane_prec_d;
    logic [SARRAY_H-1:0]         lane_acc_d;

    logic                        feed;
    logic                        rd_en;
    logic                        early;
    logic [S_W-1:0]              s_last;
    logic                        unused_bot;

    assign feed   = (state_q == ST_FEED);
    assign rd_en  = feed && (s_q < S_W'(k_q));
    assign s_last = S_W'(k_q) + S_W'(SARRAY_H - 2);
    // a bottom beat before STORE means the array emitted stray results
    assign early  = (state_q == ST_IDLE) || feed ||
                    (state_q == ST_DRAIN);
    assign unused_bot = ^bot_valid_i[SARRAY_H:1];

    for (genvar r = 0; r < SARRAY_H; r++) begin : g_lane
        sarray_lane_gen #(
            .CNT_W(CNT_W),
            .S_W  (S_W),
            .LANE (r)
        ) u_lane (
            .en_i   (feed),
            .s_i    (s_q),
            .k_i    (k_q),
            .valid_o(lane_valid_d[r]),
            .cnt_o  (lane_cnt_d[r*CNT_W +: CNT_W])
        );
        assign lane_type_d[r] = lane_valid_d[r] & type_q;
        assign lane_acc_d[r]  = lane_valid_d[r] & acc_q;
        assign lane_prec_d[r*PREC_W +: PREC_W] =
            lane_valid_d[r] ? prec_q : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            s_q          <= '0;
            d_q          <= '0;
            b_q          <= '0;
            k_q          <= '0;
            type_q       <= 1'b0;
            prec_q       <= '0;
            acc_q        <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_idx_q     <= '0;
            left_valid_q <= '0;
            left_cnt_q   <= '0;
            left_type_q  <= '0;
            left_prec_q  <= '0;
            left_acc_q   <= '0;
            post_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            left_valid_q <= lane_valid_d;
            left_cnt_q   <= lane_cnt_d;
            left_type_q  <= lane_type_d;
            left_prec_q  <= lane_prec_d;
            left_acc_q   <= {feed & acc_q, lane_acc_d};
            rd_valid_q   <= rd_en;
            rd_idx_q     <= rd_en ? s_q[CNT_W-1:0] : '0;
            post_q       <= 1'b0;
            done_q       <= 1'b0;
            if (bot_valid_i[0] && early) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        if (cmd_k_i == '0) begin
                            err_q <= 1'b1;
                        end else begin
                            k_q     <= cmd_k_i;
                            type_q  <= cmd_type_i;
                            prec_q  <= cmd_prec_i;
                            acc_q   <= cmd_acc_i;
                            s_q     <= '0;
                            b_q     <= '0;
                            busy_q  <= 1'b1;
                            state_q <= ST_FEED;
                        end
                    end
                end
                ST_FEED: begin
                    if (s_q == s_last) begin
                        d_q     <= '0;
                        state_q <= ST_DRAIN;
                    end else begin
                        s_q <= s_q + S_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (d_q == D_W'(DRAIN_CYC - 1)) begin
                        b_q     <= '0;
                        post_q  <= 1'b1;
                        state_q <= ST_STORE;
                    end else begin
                        d_q <= d_q + D_W'(1);
                    end
                end
                ST_STORE: begin
                    if (bot_valid_i[0]) begin
                        if (b_q == B_W'(SARRAY_H - 1)) begin
                            b_q     <= B_W'(SARRAY_H);
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            b_q <= b_q + B_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o         = (state_q == ST_IDLE);
    assign rd_valid_o          = rd_valid_q;
    assign rd_idx_o            = rd_idx_q;
    assign left_valid_o        = left_valid_q;
    assign left_cnt_o          = left_cnt_q;
    assign left_type_o         = left_type_q;
    assign left_prec_o         = left_prec_q;
    assign left_acc_o          = left_acc_q;
    assign top_valid_o         = left_valid_q;
    assign top_cnt_o           = left_cnt_q;
    assign post_storec_valid_o = post_q;
    assign busy_o              = busy_q;
    assign done_o              = done_q;
    assign err_o               = err_q;

endmodule

// File: tb/tb_sarray_ctrl.sv
// Directed bench for sarray_ctrl at H=4, CNT_W=8, DRAIN_CYC=8.
// Table rows give inputs plus expected outputs after the next clock edge.
module tb_sarray_ctrl;

    localparam int H = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cmd_valid_i = 1'b0;
    logic           cmd_ready_o;
    logic [7:0]     cmd_k_i = '0;
    logic           cmd_type_i = 1'b0;
    logic [1:0]     cmd_prec_i = '0;
    logic           cmd_acc_i = 1'b0;
    logic           rd_valid_o;
    logic [7:0]     rd_idx_o;
    logic [H-1:0]   left_valid_o;
    logic [8*H-1:0] left_cnt_o;
    logic [H-1:0]   left_type_o;
    logic [2*H-1:0] left_prec_o;
    logic [H:0]     left_acc_o;
    logic [H-1:0]   top_valid_o;
    logic [8*H-1:0] top_cnt_o;
    logic           post_storec_valid_o;
    logic [H:0]     bot_valid_i = '0;
    logic           busy_o;
    logic           done_o;
    logic           err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sarray_ctrl #(
        .SARRAY_H (H),
        .CNT_W    (8),
        .PREC_W   (2),
        .DRAIN_CYC(8)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cmd_valid_i        (cmd_valid_i),
        .cmd_ready_o        (cmd_ready_o),
        .cmd_k_i            (cmd_k_i),
        .cmd_type_i         (cmd_type_i),
        .cmd_prec_i         (cmd_prec_i),
        .cmd_acc_i          (cmd_acc_i),
        .rd_valid_o         (rd_valid_o),
        .rd_idx_o           (rd_idx_o),
        .left_valid_o       (left_valid_o),
        .left_cnt_o         (left_cnt_o),
        .left_type_o        (left_type_o),
        .left_prec_o        (left_prec_o),
        .left_acc_o         (left_acc_o),
        .top_valid_o        (top_valid_o),
        .top_cnt_o          (top_cnt_o),
        .post_storec_valid_o(post_storec_valid_o),
        .bot_valid_i        (bot_valid_i),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .err_o              (err_o)
    );

    typedef struct {
        logic        cv;
        logic [7:0]  k;
        logic        ty;
        logic [1:0]  pr;
        logic        ac;
        logic        bot;
        logic        rdy;
        logic        rdv;
        logic [7:0]  idx;
        logic [3:0]  lv;
        logic [31:0] lc;
        logic [3:0]  lt;
        logic [7:0]  lp;
        logic [4:0]  la;
        logic        post;
        logic        busy;
        logic        done;
        logic        err;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        logic cv, logic [7:0] k, logic ty, logic [1:0] pr,
        logic ac, logic bot, logic rdy, logic rdv,
        logic [7:0] idx, logic [3:0] lv, logic [31:0] lc,
        logic [3:0] lt, logic [7:0] lp, logic [4:0] la,
        logic post, logic busy, logic done, logic err);
        vec_t v;
        v.cv = cv;   v.k = k;     v.ty = ty;     v.pr = pr;
        v.ac = ac;   v.bot = bot; v.rdy = rdy;   v.rdv = rdv;
        v.idx = idx; v.lv = lv;   v.lc = lc;     v.lt = lt;
        v.lp = lp;   v.la = la;   v.post = post; v.busy = busy;
        v.done = done; v.err = err;
        return v;
    endfunction

    function automatic logic [102:0] pack_out();
        return {cmd_ready_o, rd_valid_o, rd_idx_o, left_valid_o,
                left_cnt_o, left_type_o, left_prec_o, left_acc_o,
                post_storec_valid_o, busy_o, done_o, err_o,
                top_valid_o, top_cnt_o};
    endfunction

    function automatic logic [102:0] pack_exp(vec_t v);
        return {v.rdy, v.rdv, v.idx, v.lv, v.lc, v.lt, v.lp, v.la,
                v.post, v.busy, v.done, v.err, v.lv, v.lc};
    endfunction

    function automatic logic [102:0] idle_exp(logic e);
        return {1'b1, 1'b0, 8'h0, 4'h0, 32'h0, 4'h0, 8'h0, 5'h0,
                1'b0, 1'b0, 1'b0, e, 4'h0, 32'h0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [102:0] exp);
        logic [102:0] act;
        act = pack_out();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic chk1(string nm, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", nm, act, exp);
        end
    endtask

    task automatic run_rows(int lo, int hi);
        for (int i = lo; i < hi; i++) begin
            cmd_valid_i = tv[i].cv;
            cmd_k_i     = tv[i].k;
            cmd_type_i  = tv[i].ty;
            cmd_prec_i  = tv[i].pr;
            cmd_acc_i   = tv[i].ac;
            bot_valid_i = {4'b0, tv[i].bot};
            step();
            chk($sformatf("row%0d", i), pack_exp(tv[i]));
        end
        cmd_valid_i = 1'b0;
        bot_valid_i = '0;
    endtask

    // wait for store-C, feed 4 bottom beats, expect one done pulse, then idle
    task automatic tail(string nm, logic e_err);
        int  n;
        bit  seen;
        n    = 0;
        seen = 0;
        while (!seen && n < 40) begin
            step();
            n++;
            if (post_storec_valid_o) seen = 1;
        end
        chk1({nm, "_post"}, seen, 1'b1);
        bot_valid_i = 5'b00001;
        for (int i = 0; i < H; i++) begin
            step();
            chk1($sformatf("%s_done%0d", nm, i), done_o, i == H - 1);
        end
        bot_valid_i = '0;
        chk1({nm, "_err"}, err_o, e_err);
        step();
        chk1({nm, "_idle"}, cmd_ready_o && !busy_o && !done_o &&
             left_valid_o == '0, 1'b1);
    endtask

    initial begin
        // K=3 type=1 prec=2 acc=1, full run
        tv.push_back(mk(1,3,1,2,1,0, 0,0,0,4'h0,32'h0,4'h0,8'h00,5'h00, 0,1,0,0));
        tv.push_back(mk(0,0,0,0,0,0, 0,1,0,4'h1,32'h00000000,4'h1,8'h02,5'h11, 0,1,0,0));
        tv.push_back(mk(0,0,0,0,0,0, 0,1,1,4'h3,32'h00000001,4'h3,8'h0A,5'h13, 0,1,0,0));
        tv.push_back(mk(0,0,0,0,0,0, 0,1,2,4'h7,32'h00000102,4'h7,8'h2A,5'h17, 0,1,0,0));
        tv.push_back(mk(0,0,0,0,0,0, 0,0,0,4'hE,32'h00010200,4'hE,8'hA8,5'h1E, 0,1,0,0));
        tv.push_back(mk(0,0,0,0,0,0, 0,0,0,4'hC,32'h01020000,4'hC,8'hA0,5'h1C, 0,1,0,0));
        tv.push_back(mk(0,0,0,0,0,0, 0,0,0,4'h8,32'h02000000,4'h8,8'h80,5'h18, 0,1,0,0));
        for (int i = 0; i < 7; i++)
            tv.push_back(mk(0,0,0,0,0,0, 0,0,0,4'h0,32'h0,4'h0,8'h00,5'h00, 0,1,0,0));
        tv.push_back(mk(0,0,0,0,0,0, 0,0,0,4'h0,32'h0,4'h0,8'h00,5'h00, 1,1,0,0));
        for (int i = 0; i < 3; i++)
            tv.push_back(mk(0,0,0,0,0,1, 0,0,0,4'h0,32'h0,4'h0,8'h00,5'h00, 0,1,0,0));
        tv.push_back(mk(0,0,0,0,0,1, 0,0,0,4'h0,32'h0,4'h0,8'h00,5'h00, 0,1,1,0));
        tv.push_back(mk(0,0,0,0,0,0, 1,0,0,4'h0,32'h0,4'h0,8'h00,5'h00, 0,0,0,0));
        // K=1 type=0 prec=1 acc=0, feed phase then first drain cycle
        tv.push_back(mk(1,1,0,1,0,0, 0,0,0,4'h0,32'h0,4'h0,8'h00,5'h00, 0,1,0,0));
        tv.push_back(mk(0,0,0,0,0,0, 0,1,0,4'h1,32'h0,4'h0,8'h01,5'h00, 0,1,0,0));
        tv.push_back(mk(0,0,0,0,0,0, 0,0,0,4'h2,32'h0,4'h0,8'h04,5'h00, 0,1,0,0));
        tv.push_back(mk(0,0,0,0,0,0, 0,0,0,4'h4,32'h0,4'h0,8'h10,5'h00, 0,1,0,0));
        tv.push_back(mk(0,0,0,0,0,0, 0,0,0,4'h8,32'h0,4'h0,8'h40,5'h00, 0,1,0,0));
        tv.push_back(mk(0,0,0,0,0,0, 0,0,0,4'h0,32'h0,4'h0,8'h00,5'h00, 0,1,0,0));

        #12;
        chk("reset", idle_exp(1'b0));
        #10 rst_n = 1'b1;
        step();
        chk("idle", idle_exp(1'b0));

        run_rows(0, 20);
        run_rows(20, 26);
        tail("k1", 1'b0);

        // command held through DONE: re-accepted only from IDLE
        cmd_valid_i = 1'b1;
        cmd_k_i     = 8'd1;
        cmd_type_i  = 1'b0;
        cmd_prec_i  = 2'd0;
        cmd_acc_i   = 1'b0;
        step();
        chk1("held_acc", busy_o, 1'b1);
        tail("held", 1'b0);
        step();
        chk1("held_reacc", busy_o && !cmd_ready_o, 1'b1);
        step();
        chk1("held_wave", left_valid_o == 4'b0001, 1'b1);
        cmd_valid_i = 1'b0;
        tail("held2", 1'b0);

        // K=0 is rejected
        cmd_valid_i = 1'b1;
        cmd_k_i     = 8'd0;
        step();
        chk("k0", idle_exp(1'b1));
        cmd_valid_i = 1'b0;
        step();
        chk("k0_sticky", idle_exp(1'b1));
        rst_n = 1'b0;
        #1;
        chk("rst_clr", idle_exp(1'b0));
        #2 rst_n = 1'b1;

        // stray bottom beat during DRAIN
        cmd_valid_i = 1'b1;
        cmd_k_i     = 8'd2;
        step();
        cmd_valid_i = 1'b0;
        repeat (5) step();
        chk1("drain_noerr", err_o, 1'b0);
        bot_valid_i = 5'b00001;
        step();
        bot_valid_i = '0;
        chk1("drain_err", err_o && busy_o, 1'b1);
        tail("drain", 1'b1);

        // asynchronous reset mid-FEED
        cmd_valid_i = 1'b1;
        cmd_k_i     = 8'd3;
        cmd_type_i  = 1'b1;
        cmd_prec_i  = 2'd3;
        cmd_acc_i   = 1'b1;
        step();
        cmd_valid_i = 1'b0;
        step();
        step();
        chk1("mid_feed", left_valid_o[1], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_async", idle_exp(1'b0));
        step();
        chk("rst_hold", idle_exp(1'b0));
        #2 rst_n = 1'b1;
        cmd_valid_i = 1'b1;
        cmd_k_i     = 8'd2;
        cmd_type_i  = 1'b1;
        cmd_prec_i  = 2'd1;
        cmd_acc_i   = 1'b0;
        step();
        cmd_valid_i = 1'b0;
        step();
        chk("post_rst_s0", {1'b0, 1'b1, 8'h0, 4'h1, 32'h0, 4'h1, 8'h01,
                            5'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 32'h0});
        tail("post_rst", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
